// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants and types for the jump/branch control sequencer:
//   - instruction opcodes decoded from IR (OP_*)
//   - ALU operation select used for PC increment and branch target add
//   - one-hot state encoding of the sequencer (ST_* / state_e)
//   - control strobe bundle produced by the state decoder (strobe_t)
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Instruction opcodes (IR[OPC_MSB:OPC_MSB-4])
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation select
    localparam logic [4:0] ALU_ADD = 5'b00011;

    // One-hot state encoding
    localparam int unsigned STATE_W = 13;
    localparam logic [STATE_W-1:0] ST_RESET  = 13'h0001;
    localparam logic [STATE_W-1:0] ST_T0     = 13'h0002;
    localparam logic [STATE_W-1:0] ST_T1     = 13'h0004;
    localparam logic [STATE_W-1:0] ST_T2     = 13'h0008;
    localparam logic [STATE_W-1:0] ST_T3     = 13'h0010;
    localparam logic [STATE_W-1:0] ST_JAL_T3 = 13'h0020;
    localparam logic [STATE_W-1:0] ST_JAL_T4 = 13'h0040;
    localparam logic [STATE_W-1:0] ST_JR_T3  = 13'h0080;
    localparam logic [STATE_W-1:0] ST_BR_T3  = 13'h0100;
    localparam logic [STATE_W-1:0] ST_BR_T4  = 13'h0200;
    localparam logic [STATE_W-1:0] ST_BR_T5  = 13'h0400;
    localparam logic [STATE_W-1:0] ST_BR_T6  = 13'h0800;
    localparam logic [STATE_W-1:0] ST_HALT   = 13'h1000;

    typedef enum logic [STATE_W-1:0] {
        StReset = ST_RESET,
        StT0    = ST_T0,
        StT1    = ST_T1,
        StT2    = ST_T2,
        StT3    = ST_T3,
        StJalT3 = ST_JAL_T3,
        StJalT4 = ST_JAL_T4,
        StJrT3  = ST_JR_T3,
        StBrT3  = ST_BR_T3,
        StBrT4  = ST_BR_T4,
        StBrT5  = ST_BR_T5,
        StBrT6  = ST_BR_T6,
        StHalt  = ST_HALT
    } state_e;

    // Control strobes decoded from the state alone
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic c_out;
        logic r_out;
        logic ba_out;
        logic mar_en;
        logic mdr_en;
        logic ir_en;
        logic pc_en;
        logic pc_en_con;  // PC load qualified by CON_FF (branch taken)
        logic y_en;
        logic z_en;
        logic con_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic rins_link;  // load the link register directly
        logic alu_add;
        logic run;
    } strobe_t;

    function automatic logic is_legal_opc(input logic [4:0] opc);
        return (opc == OP_BR) || (opc == OP_JR) || (opc == OP_JAL) ||
               (opc == OP_NOP) || (opc == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// ----------------------------------------------------------------------------
// ctrl_strobe_decode
// Purely combinational map from sequencer state to control strobe bundle.
// Ports:
//   i_state  in   state_e   current sequencer state
//   o_str    out  strobe_t  strobes asserted in that state
// ----------------------------------------------------------------------------
module ctrl_strobe_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e  i_state,
    output strobe_t o_str
);

    always_comb begin
        o_str     = '0;
        o_str.run = 1'b1;
        unique case (i_state)
            StReset: o_str.run = 1'b0;
            StT0: begin
                o_str.pc_out  = 1'b1;
                o_str.mar_en  = 1'b1;
                o_str.inc_pc  = 1'b1;
                o_str.z_en    = 1'b1;
                o_str.alu_add = 1'b1;
            end
            StT1: begin
                o_str.zlow_out = 1'b1;
                o_str.pc_en    = 1'b1;
                o_str.read     = 1'b1;
                o_str.mdr_en   = 1'b1;
            end
            StT2: begin
                o_str.mdr_out = 1'b1;
                o_str.ir_en   = 1'b1;
            end
            StT3: ;
            StJalT3: begin
                o_str.pc_out    = 1'b1;
                o_str.rins_link = 1'b1;
            end
            StJalT4, StJrT3: begin
                o_str.gra   = 1'b1;
                o_str.r_out = 1'b1;
                o_str.pc_en = 1'b1;
            end
            StBrT3: begin
                o_str.gra    = 1'b1;
                o_str.r_out  = 1'b1;
                o_str.con_in = 1'b1;
            end
            StBrT4: begin
                o_str.pc_out = 1'b1;
                o_str.y_en   = 1'b1;
            end
            StBrT5: begin
                o_str.c_out   = 1'b1;
                o_str.alu_add = 1'b1;
                o_str.z_en    = 1'b1;
            end
            StBrT6: begin
                o_str.zlow_out  = 1'b1;
                o_str.pc_en_con = 1'b1;
            end
            StHalt:  o_str.run = 1'b0;
            default: o_str.run = 1'b0;
        endcase
    end

endmodule

// File: rtl/jump_branch_control_unit.sv
// ----------------------------------------------------------------------------
// jump_branch_control_unit
// Hardwired one-hot Moore sequencer for fetch and the jal/jr/br/nop/halt
// instruction class. Holds the state register, next-state logic and the
// sticky illegal-opcode flag; strobes come from ctrl_strobe_decode.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (trap unknown opcodes to HALT).
// Ports:
//   Clock, clr (sync active-high reset), IR, CON_FF, Stop (sampled in T0)
//   bus drives:   PC_out ZLow_out MDR_out C_out R_out BA_out
//   load enables: MAR_enable MDR_enable IR_enable PC_enable Y_enable Z_enable con_in
//   controls:     IncPC Read Gra Grb Grc R_in, Rins[15:0], opcode[4:0]
//   status:       Run, illegal_op
// ----------------------------------------------------------------------------
module jump_branch_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned LINK_REG = 15,
    parameter int unsigned OPC_MSB  = 31
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PC_out,
    output logic        ZLow_out,
    output logic        MDR_out,
    output logic        C_out,
    output logic        R_out,
    output logic        BA_out,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        PC_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        con_in,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic [15:0] Rins,
    output logic [4:0]  opcode,
    output logic        Run,
    output logic        illegal_op
);

    state_e      r_state;
    state_e      w_state_d;
    strobe_t     w_str;
    logic [4:0]  w_opc;
    logic        w_unused_ir;

    assign w_opc       = IR[OPC_MSB -: 5];
    assign w_unused_ir = ^IR;

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op;
    logic w_set_illegal;
`endif

    // IR is expected to hold the new instruction by the T2->T3 edge; the
    // opcode then selects which T3 step to enter.
    always_comb begin
        w_state_d = r_state;
`ifdef ILLEGAL_OP_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        unique case (r_state)
            StReset: w_state_d = StT0;
            StT0:    w_state_d = Stop ? StHalt : StT1;
            StT1:    w_state_d = StT2;
            StT2: begin
                if (w_opc == OP_JAL)     w_state_d = StJalT3;
                else if (w_opc == OP_JR) w_state_d = StJrT3;
                else if (w_opc == OP_BR) w_state_d = StBrT3;
                else                     w_state_d = StT3;
            end
            StT3: begin
                if (w_opc == OP_HALT) begin
                    w_state_d = StHalt;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                else if (!is_legal_opc(w_opc)) begin
                    w_state_d     = StHalt;
                    w_set_illegal = 1'b1;
                end
`endif
                else begin
                    w_state_d = StT0;
                end
            end
            StJalT3: w_state_d = StJalT4;
            StJalT4: w_state_d = StT0;
            StJrT3:  w_state_d = StT0;
            StBrT3:  w_state_d = StBrT4;
            StBrT4:  w_state_d = StBrT5;
            StBrT5:  w_state_d = StBrT6;
            StBrT6:  w_state_d = StT0;
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StReset;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr) begin
            r_state <= StReset;
`ifdef ILLEGAL_OP_TRAP_EN
            r_illegal_op <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
`ifdef ILLEGAL_OP_TRAP_EN
            if (w_set_illegal) r_illegal_op <= 1'b1;
`endif
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

    ctrl_strobe_decode u_decode (
        .i_state (r_state),
        .o_str   (w_str)
    );

    assign PC_out     = w_str.pc_out;
    assign ZLow_out   = w_str.zlow_out;
    assign MDR_out    = w_str.mdr_out;
    assign C_out      = w_str.c_out;
    assign R_out      = w_str.r_out;
    assign BA_out     = w_str.ba_out;
    assign MAR_enable = w_str.mar_en;
    assign MDR_enable = w_str.mdr_en;
    assign IR_enable  = w_str.ir_en;
    // Only Mealy path: branch-taken PC load in BR_T6
    assign PC_enable  = w_str.pc_en | (w_str.pc_en_con & CON_FF);
    assign Y_enable   = w_str.y_en;
    assign Z_enable   = w_str.z_en;
    assign con_in     = w_str.con_in;
    assign IncPC      = w_str.inc_pc;
    assign Read       = w_str.read;
    assign Gra        = w_str.gra;
    assign Grb        = w_str.grb;
    assign Grc        = w_str.grc;
    assign R_in       = w_str.r_in;
    assign Rins       = 16'(w_str.rins_link) << LINK_REG;
    assign opcode     = w_str.alu_add ? ALU_ADD : 5'b00000;
    assign Run        = w_str.run;

endmodule

// File: tb/tb_jump_branch_control_unit.sv
// ----------------------------------------------------------------------------
// tb_jump_branch_control_unit
// Directed, cycle-by-cycle check of the jump/branch sequencer outputs.
// ----------------------------------------------------------------------------
module tb_jump_branch_control_unit;
    import cpu_ctrl_pkg::*;

    logic        Clock;
    logic        clr;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic        PC_out, ZLow_out, MDR_out, C_out, R_out, BA_out;
    logic        MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable, Z_enable, con_in;
    logic        IncPC, Read, Gra, Grb, Grc, R_in;
    logic [15:0] Rins;
    logic [4:0]  opcode;
    logic        Run;
    logic        illegal_op;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_ill = 1'b0;

    // Bit positions of the strobe vector compared each cycle
    localparam logic [18:0] M_PC_OUT  = 19'd1 << 18;
    localparam logic [18:0] M_ZLOW    = 19'd1 << 17;
    localparam logic [18:0] M_MDR_OUT = 19'd1 << 16;
    localparam logic [18:0] M_C_OUT   = 19'd1 << 15;
    localparam logic [18:0] M_R_OUT   = 19'd1 << 14;
    localparam logic [18:0] M_MAR_EN  = 19'd1 << 12;
    localparam logic [18:0] M_MDR_EN  = 19'd1 << 11;
    localparam logic [18:0] M_IR_EN   = 19'd1 << 10;
    localparam logic [18:0] M_PC_EN   = 19'd1 << 9;
    localparam logic [18:0] M_Y_EN    = 19'd1 << 8;
    localparam logic [18:0] M_Z_EN    = 19'd1 << 7;
    localparam logic [18:0] M_CON_IN  = 19'd1 << 6;
    localparam logic [18:0] M_INC_PC  = 19'd1 << 5;
    localparam logic [18:0] M_READ    = 19'd1 << 4;
    localparam logic [18:0] M_GRA     = 19'd1 << 3;

    localparam logic [18:0] E_NONE = 19'd0;
    localparam logic [18:0] E_T0   = M_PC_OUT | M_MAR_EN | M_INC_PC | M_Z_EN;
    localparam logic [18:0] E_T1   = M_ZLOW | M_PC_EN | M_READ | M_MDR_EN;
    localparam logic [18:0] E_T2   = M_MDR_OUT | M_IR_EN;
    localparam logic [18:0] E_GRP  = M_GRA | M_R_OUT | M_PC_EN;

    jump_branch_control_unit dut (
        .Clock      (Clock),
        .clr        (clr),
        .IR         (IR),
        .CON_FF     (CON_FF),
        .Stop       (Stop),
        .PC_out     (PC_out),
        .ZLow_out   (ZLow_out),
        .MDR_out    (MDR_out),
        .C_out      (C_out),
        .R_out      (R_out),
        .BA_out     (BA_out),
        .MAR_enable (MAR_enable),
        .MDR_enable (MDR_enable),
        .IR_enable  (IR_enable),
        .PC_enable  (PC_enable),
        .Y_enable   (Y_enable),
        .Z_enable   (Z_enable),
        .con_in     (con_in),
        .IncPC      (IncPC),
        .Read       (Read),
        .Gra        (Gra),
        .Grb        (Grb),
        .Grc        (Grc),
        .R_in       (R_in),
        .Rins       (Rins),
        .opcode     (opcode),
        .Run        (Run),
        .illegal_op (illegal_op)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [18:0] es, input logic [15:0] er,
                         input logic [4:0] eo, input logic erun);
        logic [18:0] s;
        logic [5:0]  bus;
        s = {PC_out, ZLow_out, MDR_out, C_out, R_out, BA_out, MAR_enable, MDR_enable,
             IR_enable, PC_enable, Y_enable, Z_enable, con_in, IncPC, Read, Gra, Grb, Grc,
             R_in};
        bus = {PC_out, ZLow_out, MDR_out, C_out, R_out, BA_out};
        n_cmp++;
        assert (s === es) else begin
            n_fail++;
            $error("FAIL %s strobes: got %h want %h", tag, s, es);
        end
        n_cmp++;
        assert (Rins === er) else begin
            n_fail++;
            $error("FAIL %s Rins: got %h want %h", tag, Rins, er);
        end
        n_cmp++;
        assert (opcode === eo) else begin
            n_fail++;
            $error("FAIL %s opcode: got %b want %b", tag, opcode, eo);
        end
        n_cmp++;
        assert (Run === erun) else begin
            n_fail++;
            $error("FAIL %s Run: got %b want %b", tag, Run, erun);
        end
        n_cmp++;
        assert (illegal_op === exp_ill) else begin
            n_fail++;
            $error("FAIL %s illegal_op: got %b want %b", tag, illegal_op, exp_ill);
        end
        n_cmp++;
        assert ($countones(bus) <= 1) else begin
            n_fail++;
            $error("FAIL %s bus_onehot: got %b want at most one bit", tag, bus);
        end
    endtask

    task automatic fetch(input string tag);
        step(); check({tag, "_t0"}, E_T0, 16'h0, ALU_ADD, 1'b1);
        step(); check({tag, "_t1"}, E_T1, 16'h0, 5'd0, 1'b1);
        step(); check({tag, "_t2"}, E_T2, 16'h0, 5'd0, 1'b1);
    endtask

    task automatic br_tail(input string tag, input logic [18:0] e_t6);
        step(); check({tag, "_t3"}, M_GRA | M_R_OUT | M_CON_IN, 16'h0, 5'd0, 1'b1);
        step(); check({tag, "_t4"}, M_PC_OUT | M_Y_EN, 16'h0, 5'd0, 1'b1);
        step(); check({tag, "_t5"}, M_C_OUT | M_Z_EN, 16'h0, ALU_ADD, 1'b1);
        step(); check({tag, "_t6"}, e_t6, 16'h0, 5'd0, 1'b1);
    endtask

    initial begin
        clr    = 1'b1;
        IR     = 32'h0;
        CON_FF = 1'b0;
        Stop   = 1'b0;

        // Reset held two cycles
        step(); check("rst1", E_NONE, 16'h0, 5'd0, 1'b0);
        step(); check("rst2", E_NONE, 16'h0, 5'd0, 1'b0);
        clr = 1'b0;

        // jal: link register load then jump
        IR = {OP_JAL, 27'd0};
        fetch("jal");
        step(); check("jal_t3", M_PC_OUT, 16'h8000, 5'd0, 1'b1);
        step(); check("jal_t4", E_GRP, 16'h0, 5'd0, 1'b1);

        // br taken then not taken
        IR = {OP_BR, 27'd0};
        CON_FF = 1'b1;
        fetch("br1");
        br_tail("br1", M_ZLOW | M_PC_EN);
        CON_FF = 1'b0;
        fetch("br0");
        br_tail("br0", M_ZLOW);

        // jr, with Stop toggled outside T0 (must be ignored)
        IR = {OP_JR, 27'd0};
        fetch("jr");
        Stop = 1'b1;
        step(); check("jr_t3", E_GRP, 16'h0, 5'd0, 1'b1);
        Stop = 1'b0;

        // nop: idle T3 then back to fetch
        IR = {OP_NOP, 27'd0};
        fetch("nop");
        step(); check("nop_t3", E_NONE, 16'h0, 5'd0, 1'b1);

        // Unknown opcode
        IR = {5'b11111, 27'd0};
        fetch("ill");
        step(); check("ill_t3", E_NONE, 16'h0, 5'd0, 1'b1);
`ifdef ILLEGAL_OP_TRAP_EN
        exp_ill = 1'b1;
        step(); check("ill_halt", E_NONE, 16'h0, 5'd0, 1'b0);
        step(); check("ill_hold", E_NONE, 16'h0, 5'd0, 1'b0);
        clr = 1'b1;
        exp_ill = 1'b0;
        step(); check("ill_clr", E_NONE, 16'h0, 5'd0, 1'b0);
        clr = 1'b0;
`endif
        IR = {OP_NOP, 27'd0};
        step(); check("ill_t0", E_T0, 16'h0, ALU_ADD, 1'b1);

        // Stop in T0 -> HALT, held for 10 cycles
        Stop = 1'b1;
        step(); check("stop_halt", E_NONE, 16'h0, 5'd0, 1'b0);
        Stop = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(); check("stop_hold", E_NONE, 16'h0, 5'd0, 1'b0);
        end

        // clr out of HALT, then clr in the middle of BR_T5
        clr = 1'b1;
        step(); check("halt_clr", E_NONE, 16'h0, 5'd0, 1'b0);
        clr = 1'b0;
        IR = {OP_BR, 27'd0};
        fetch("brc");
        step(); check("brc_t3", M_GRA | M_R_OUT | M_CON_IN, 16'h0, 5'd0, 1'b1);
        step(); check("brc_t4", M_PC_OUT | M_Y_EN, 16'h0, 5'd0, 1'b1);
        step(); check("brc_t5", M_C_OUT | M_Z_EN, 16'h0, ALU_ADD, 1'b1);
        clr = 1'b1;
        step(); check("brc_rst", E_NONE, 16'h0, 5'd0, 1'b0);
        clr = 1'b0;

        // halt instruction
        IR = {OP_HALT, 27'd0};
        fetch("hlt");
        step(); check("hlt_t3", E_NONE, 16'h0, 5'd0, 1'b1);
        step(); check("hlt_halt", E_NONE, 16'h0, 5'd0, 1'b0);
        step(); check("hlt_hold", E_NONE, 16'h0, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
